// File: rtl/cpu_alu_pkg.sv
// Shared ALU result-bus definitions: field widths, flag bit positions and payload types.
package cpu_alu_pkg;

  localparam int unsigned ALU_DATA_W     = 32;
  localparam int unsigned ALU_OUT_W      = 36;
  localparam int unsigned ALU_REG_ADDR_W = 4;

  localparam int unsigned FLAG_N = 35;
  localparam int unsigned FLAG_Z = 34;
  localparam int unsigned FLAG_C = 33;
  localparam int unsigned FLAG_V = 32;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic [ALU_REG_ADDR_W-1:0] dest;
    nzcv_t                     flags;
    logic [ALU_DATA_W-1:0]     data;
  } alu_entry_t;

  // Extract the flag nibble from a full-width ALU result word.
  function automatic nzcv_t alu_flags(input logic [ALU_OUT_W-1:0] word);
    return nzcv_t'(word[FLAG_N:FLAG_V]);
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU-result / writeback / condition-code bundle; ALU_STICKY_OVF_EN adds sticky_v/sticky_clr.
interface alu_result_stage_if #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W+3:0]     alu_out;
  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_dest;
  logic                  in_ready;
  logic                  flush;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [DATA_W-1:0]     wb_data;
  logic [REG_ADDR_W-1:0] wb_reg;
  logic [3:0]            wb_flags;
  logic [3:0]            cc_reg;
  logic [CNT_W-1:0]      count;
`ifdef ALU_STICKY_OVF_EN
  logic                  sticky_v;
  logic                  sticky_clr;

  modport master (
    output alu_out, alu_valid, alu_dest, flush, wb_ready, sticky_clr,
    input  in_ready, wb_valid, wb_data, wb_reg, wb_flags, cc_reg, count, sticky_v
  );
  modport slave (
    input  alu_out, alu_valid, alu_dest, flush, wb_ready, sticky_clr,
    output in_ready, wb_valid, wb_data, wb_reg, wb_flags, cc_reg, count, sticky_v
  );
`else
  modport master (
    output alu_out, alu_valid, alu_dest, flush, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_reg, wb_flags, cc_reg, count
  );
  modport slave (
    input  alu_out, alu_valid, alu_dest, flush, wb_ready,
    output in_ready, wb_valid, wb_data, wb_reg, wb_flags, cc_reg, count
  );
`endif
endinterface

// File: rtl/result_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with push/pop/flush; read data reads 0 when empty.
module result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 40
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/alu_result_stage.sv
// Buffers ALU results for writeback and tracks the architectural NZCV register.
// Optional sticky overflow flag when ALU_STICKY_OVF_EN is defined.
module alu_result_stage
  import cpu_alu_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DATA_W     = ALU_DATA_W,
  parameter int unsigned REG_ADDR_W = ALU_REG_ADDR_W
) (
  input logic               clk,
  input logic               reset,
  alu_result_stage_if.slave bus
);
  localparam int unsigned ENTRY_W = REG_ADDR_W + 4 + DATA_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_accept;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;
  logic [CNT_W-1:0]   w_count;
  nzcv_t              w_push_flags;
  nzcv_t              r_cc;

  assign w_push_flags = nzcv_t'(bus.alu_out[DATA_W+3:DATA_W]);
  assign w_wdata      = {bus.alu_dest, w_push_flags, bus.alu_out[DATA_W-1:0]};
  assign w_push       = bus.alu_valid & ~w_full;
  assign w_pop        = ~w_empty & bus.wb_ready;
  // A flushed push never lands, so it must not touch architectural state.
  assign w_accept     = w_push & ~bus.flush;

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.flush),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.in_ready = ~w_full;
  assign bus.wb_valid = ~w_empty;
  assign {bus.wb_reg, bus.wb_flags, bus.wb_data} = w_rdata;
  assign bus.count    = w_count;
  assign bus.cc_reg   = r_cc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_cc <= '0;
    else if (w_accept) r_cc <= w_push_flags;
  end

`ifdef ALU_STICKY_OVF_EN
  logic r_sticky_v;

  // Set takes priority over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           r_sticky_v <= 1'b0;
    else if (w_accept && w_push_flags.v) r_sticky_v <= 1'b1;
    else if (bus.sticky_clr)             r_sticky_v <= 1'b0;
  end

  assign bus.sticky_v = r_sticky_v;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage (DEPTH=2); sticky checks when ALU_STICKY_OVF_EN is defined.
module tb_alu_result_stage;
  localparam int unsigned DEPTH      = 2;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [39:0] exp_q[$];

  alu_result_stage_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

  alu_result_stage #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [35:0] word, input logic [3:0] dest, input bit expect_accept);
    bus.alu_valid = 1'b1;
    bus.alu_out   = word;
    bus.alu_dest  = dest;
    if (expect_accept) exp_q.push_back({dest, word});
  endtask

  // Monitor: an entry presented with wb_ready at the falling edge pops at the next rising edge.
  always @(negedge clk) begin
    if (!reset && !bus.flush && bus.wb_valid && bus.wb_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_unexpected: got %0h expected none", {bus.wb_reg, bus.wb_flags, bus.wb_data});
      end else begin
        check("pop_entry", 64'({bus.wb_reg, bus.wb_flags, bus.wb_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    bus.alu_out    = '0;
    bus.alu_valid  = 1'b0;
    bus.alu_dest   = '0;
    bus.flush      = 1'b0;
    bus.wb_ready   = 1'b0;
`ifdef ALU_STICKY_OVF_EN
    bus.sticky_clr = 1'b0;
`endif
    #1;
    check("rst_count",    64'(bus.count),    64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_cc",       64'(bus.cc_reg),   64'd0);
    check("rst_wb_data",  64'(bus.wb_data),  64'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // Single push, no pop
    set_push(36'h8_FFFF_FFFF, 4'd3, 1'b1);
    step();
    bus.alu_valid = 1'b0;
    check("p1_wb_valid", 64'(bus.wb_valid), 64'd1);
    check("p1_wb_data",  64'(bus.wb_data),  64'hFFFF_FFFF);
    check("p1_wb_reg",   64'(bus.wb_reg),   64'd3);
    check("p1_wb_flags", 64'(bus.wb_flags), 64'b1000);
    check("p1_cc",       64'(bus.cc_reg),   64'b1000);
    check("p1_count",    64'(bus.count),    64'd1);

    // Fill to DEPTH, then an ignored push
    set_push(36'h1_0000_0005, 4'd5, 1'b1);
    step();
    check("full_count",    64'(bus.count),    64'd2);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_cc",       64'(bus.cc_reg),   64'b0001);
    set_push(36'h2_1234_5678, 4'd7, 1'b0);
    step();
    bus.alu_valid = 1'b0;
    check("ign_count",   64'(bus.count),   64'd2);
    check("ign_cc",      64'(bus.cc_reg),  64'b0001);
    check("hold_wbdata", 64'(bus.wb_data), 64'hFFFF_FFFF);
    bus.wb_ready = 1'b1;
    step();
    check("drain1_count", 64'(bus.count), 64'd1);
    step();
    bus.wb_ready = 1'b0;
    check("drain2_count", 64'(bus.count),    64'd0);
    check("empty_valid",  64'(bus.wb_valid), 64'd0);
    check("empty_data",   64'(bus.wb_data),  64'd0);
    check("empty_flags",  64'(bus.wb_flags), 64'd0);

    // Push and pop together at count=1
    set_push(36'h0_0000_00AA, 4'd2, 1'b1);
    step();
    set_push(36'h4_0000_0000, 4'd9, 1'b1);
    bus.wb_ready = 1'b1;
    step();
    bus.alu_valid = 1'b0;
    bus.wb_ready  = 1'b0;
    check("pp_count", 64'(bus.count),    64'd1);
    check("pp_data",  64'(bus.wb_data),  64'd0);
    check("pp_flags", 64'(bus.wb_flags), 64'b0100);
    check("pp_reg",   64'(bus.wb_reg),   64'd9);
    check("pp_cc",    64'(bus.cc_reg),   64'b0100);

    // Flush overrides a concurrent push
    set_push(36'h1_0000_0001, 4'd1, 1'b0);
    bus.flush = 1'b1;
    exp_q.delete();
    step();
    bus.flush     = 1'b0;
    bus.alu_valid = 1'b0;
    check("fl_count",    64'(bus.count),    64'd0);
    check("fl_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("fl_cc",       64'(bus.cc_reg),   64'b0100);
    check("fl_in_ready", 64'(bus.in_ready), 64'd1);

`ifdef ALU_STICKY_OVF_EN
    check("st_prior", 64'(bus.sticky_v), 64'd1);
    bus.sticky_clr = 1'b1;
    step();
    bus.sticky_clr = 1'b0;
    check("st_clr0", 64'(bus.sticky_v), 64'd0);
    bus.wb_ready = 1'b1;
    set_push(36'h1_0000_0011, 4'd1, 1'b1);
    step();
    check("st_set", 64'(bus.sticky_v), 64'd1);
    set_push(36'h0_0000_0022, 4'd2, 1'b1);
    step();
    bus.alu_valid = 1'b0;
    check("st_hold", 64'(bus.sticky_v), 64'd1);
    bus.sticky_clr = 1'b1;
    step();
    bus.sticky_clr = 1'b0;
    check("st_clr", 64'(bus.sticky_v), 64'd0);
    bus.sticky_clr = 1'b1;
    set_push(36'h1_0000_0033, 4'd3, 1'b1);
    step();
    bus.sticky_clr = 1'b0;
    bus.alu_valid  = 1'b0;
    check("st_setwins", 64'(bus.sticky_v), 64'd1);
    step();
    step();
    bus.wb_ready = 1'b0;
`endif

    // Back-to-back stream through the wrapping pointers
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_push({4'(i), 32'hA000_0000 + 32'(i)}, 4'(i + 8), 1'b1);
      step();
    end
    bus.alu_valid = 1'b0;
    check("stream_cc", 64'(bus.cc_reg), 64'd4);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    bus.wb_ready = 1'b0;
    check("stream_drained", 64'(exp_q.size()), 64'd0);
    check("stream_count",   64'(bus.count),    64'd0);

    // Asynchronous reset mid-stream at count=1
    set_push(36'h6_0000_0077, 4'd4, 1'b1);
    step();
    bus.alu_valid = 1'b0;
    check("pre_rst_count", 64'(bus.count),  64'd1);
    check("pre_rst_cc",    64'(bus.cc_reg), 64'b0110);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("arst_cc",       64'(bus.cc_reg),   64'd0);
    check("arst_count",    64'(bus.count),    64'd0);
    check("arst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_wb_data",  64'(bus.wb_data),  64'd0);
    step();
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
